timer_event_capture: RTL and testbench

- Downstream consumer of the timer host outputs (timer_value, timer_overflow, timer_match, timer_active).
- Detects rising/falling edges on the status flags and records each as a timestamped event record in a small FIFO.
- Software or a bus bridge drains the FIFO over a valid/ready port. A level interrupt signals backlog.
- Gives the system a lossless or loss-counted log of timer activity between CPU polls.

---
 rtl/timer_event_capture.sv | 138 +++++++++++++
 tb/tb_timer_event_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_event_capture.sv
// timer_event_capture: logs timer flag edges as records in a first-word-fall-through FIFO with an irq.
// Timestamp counter and stamp capture are present only when TIMER_EVT_TIMESTAMP_EN is defined.
module timer_event_capture #(
    parameter int TIMER_WIDTH = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_WIDTH    = 16,
    parameter int IRQ_THRESH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TIMER_WIDTH-1:0]        timer_value,
    input  logic                          timer_overflow,
    input  logic                          timer_match,
    input  logic                          timer_active,
    input  logic                          irq_en,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [1:0]                    evt_type,
    output logic [TIMER_WIDTH-1:0]        evt_value,
    output logic [TS_WIDTH-1:0]           evt_stamp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    lost_count,
    output logic                          irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic                   prev_active_q, prev_match_q, prev_overflow_q;
    logic [3:0]             pend_q, pend_d, evt_det, cap_en, push_sel;
    logic [TIMER_WIDTH-1:0] cap_val_q [4];
    logic [TIMER_WIDTH-1:0] cap_val_d [4];
    logic [TIMER_WIDTH-1:0] mem_val_q [FIFO_DEPTH];
    logic [TIMER_WIDTH-1:0] mem_val_d [FIFO_DEPTH];
    logic [1:0]             mem_type_q [FIFO_DEPTH];
    logic [1:0]             mem_type_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [7:0]             lost_q, lost_d;
    logic                   irq_q, irq_d;
    logic                   push, pop;
    logic [1:0]             push_type;

    assign evt_valid  = count_q != '0;
    assign evt_type   = evt_valid ? mem_type_q[rd_ptr_q] : 2'd0;
    assign evt_value  = evt_valid ? mem_val_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign lost_count = lost_q;
    assign irq        = irq_q;

    always_comb begin
        pop       = evt_valid & evt_ready;
        push_type = pend_q[3] ? 2'd3 : pend_q[2] ? 2'd2 : pend_q[1] ? 2'd1 : 2'd0;
        push      = (|pend_q) & ((count_q != CW'(FIFO_DEPTH)) | pop);
        push_sel  = push ? 4'b0001 << push_type : 4'b0000;
        evt_det   = {timer_overflow & ~prev_overflow_q, timer_match & ~prev_match_q,
                     ~timer_active & prev_active_q, timer_active & ~prev_active_q};
        // A type being pushed this cycle frees its slot, so a same-cycle edge refills it
        cap_en    = evt_det & (~pend_q | push_sel);
        pend_d    = (pend_q & ~push_sel) | cap_en;
        lost_d    = lost_q;
        cap_val_d = cap_val_q;
        for (int t = 0; t < 4; t++) begin
            if (evt_det[t] && !cap_en[t] && lost_d != 8'hff)
                lost_d = lost_d + 8'd1;
            if (cap_en[t])
                cap_val_d[t] = timer_value;
        end
        mem_val_d  = mem_val_q;
        mem_type_d = mem_type_q;
        if (push) begin
            mem_val_d[wr_ptr_q]  = cap_val_q[push_type];
            mem_type_d[wr_ptr_q] = push_type;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        irq_d    = irq_en & (count_d >= CW'(IRQ_THRESH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_active_q   <= 1'b0;
            prev_match_q    <= 1'b0;
            prev_overflow_q <= 1'b0;
            pend_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            lost_q          <= '0;
            irq_q           <= 1'b0;
        end else begin
            prev_active_q   <= timer_active;
            prev_match_q    <= timer_match;
            prev_overflow_q <= timer_overflow;
            pend_q          <= pend_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            lost_q          <= lost_d;
            irq_q           <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        cap_val_q  <= cap_val_d;
        mem_val_q  <= mem_val_d;
        mem_type_q <= mem_type_d;
    end

`ifdef TIMER_EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] cap_ts_q [4];
    logic [TS_WIDTH-1:0] cap_ts_d [4];
    logic [TS_WIDTH-1:0] mem_ts_q [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] mem_ts_d [FIFO_DEPTH];

    assign evt_stamp = evt_valid ? mem_ts_q[rd_ptr_q] : '0;

    always_comb begin
        ts_d     = ts_q + TS_WIDTH'(1);
        cap_ts_d = cap_ts_q;
        mem_ts_d = mem_ts_q;
        for (int t = 0; t < 4; t++)
            if (cap_en[t])
                cap_ts_d[t] = ts_q;
        if (push)
            mem_ts_d[wr_ptr_q] = cap_ts_q[push_type];
    end

    always_ff @(posedge clk) begin
        ts_q     <= !rst ? '0 : ts_d;
        cap_ts_q <= cap_ts_d;
        mem_ts_q <= mem_ts_d;
    end
`else
    assign evt_stamp = '0;
`endif
endmodule

// File: tb/tb_timer_event_capture.sv
// tb_timer_event_capture: randomized + directed bench; a queue-based reference model feeds a scoreboard.
module tb_timer_event_capture;
    localparam int D = 8;
    localparam int THRESH = 4;
`ifdef TIMER_EVT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] v;
        logic [15:0] s;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, act, mat, ovf, irq_en, ready;
    logic [31:0] val;
    logic        evt_valid, irq;
    logic [1:0]  evt_type;
    logic [31:0] evt_value;
    logic [15:0] evt_stamp;
    logic [3:0]  fifo_count;
    logic [7:0]  lost_count;

    int checks = 0;
    int errors = 0;

    rec_t        exp_q[$];
    int          m_count = 0;
    int          m_lost = 0;
    bit          m_irq = 1'b0;
    bit          m_pend[4];
    logic [31:0] m_pv[4];
    logic [15:0] m_ps[4];
    logic [15:0] m_ts = '0;
    bit          pa = 1'b0, pm = 1'b0, po = 1'b0;
    bit          det[4];
    int          sel;
    bit          m_push, m_pop;
    rec_t        r;

    timer_event_capture dut (
        .clk(clk), .rst(rst), .timer_value(val), .timer_overflow(ovf),
        .timer_match(mat), .timer_active(act), .irq_en(irq_en), .evt_ready(ready),
        .evt_valid(evt_valid), .evt_type(evt_type), .evt_value(evt_value),
        .evt_stamp(evt_stamp), .fifo_count(fifo_count), .lost_count(lost_count), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: per-type one-deep slot, FIFO as a queue of expected records
    always @(posedge clk) begin
        if (!rst) begin
            m_count = 0; m_lost = 0; m_irq = 0; m_ts = '0;
            pa = 0; pm = 0; po = 0;
            for (int t = 0; t < 4; t++) m_pend[t] = 0;
            exp_q.delete();
        end else begin
            det[0] = act && !pa;
            det[1] = !act && pa;
            det[2] = mat && !pm;
            det[3] = ovf && !po;
            m_pop = m_count > 0 && ready;
            sel = -1;
            for (int t = 3; t >= 0; t--)
                if (sel < 0 && m_pend[t]) sel = t;
            m_push = sel >= 0 && (m_count < D || m_pop);
            if (m_push) begin
                r.t = 2'(sel);
                r.v = m_pv[sel];
                r.s = TS_EN ? m_ps[sel] : 16'd0;
                exp_q.push_back(r);
                m_pend[sel] = 0;
            end
            for (int t = 0; t < 4; t++)
                if (det[t]) begin
                    if (!m_pend[t]) begin
                        m_pend[t] = 1;
                        m_pv[t] = val;
                        m_ps[t] = m_ts;
                    end else if (m_lost < 255) m_lost++;
                end
            m_count += int'(m_push) - int'(m_pop);
            m_irq = irq_en && m_count >= THRESH;
            pa = act; pm = mat; po = ovf;
            m_ts = m_ts + 16'd1;
        end
    end

    // Monitor: status each cycle, record contents on every handshake
    always @(negedge clk) begin
        chk("fifo_count", fifo_count, m_count);
        chk("lost_count", lost_count, m_lost);
        chk("irq", irq, m_irq);
        chk("evt_valid", evt_valid, m_count > 0);
        if (evt_valid && ready) begin
            if (exp_q.size() == 0) chk("unexpected_record", 1, 0);
            else begin
                r = exp_q.pop_front();
                chk("evt_type", evt_type, r.t);
                chk("evt_value", evt_value, r.v);
                chk("evt_stamp", evt_stamp, r.s);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic match_pulses(input int n);
        repeat (n) begin
            mat = 1; val = $urandom; tick(1);
            mat = 0; tick(2);
        end
    endtask

    initial begin
        rst = 0; act = 0; mat = 0; ovf = 0; irq_en = 0; ready = 0; val = '0;
        tick(3);
        rst = 1;
        // start record with value 0x100
        tick(10);
        act = 1; val = 32'h100; ready = 1;
        tick(1);
        val = $urandom;
        tick(5);
        // simultaneous overflow and match: serialised, nothing lost
        ovf = 1; mat = 1; val = $urandom;
        tick(1);
        ovf = 0; mat = 0;
        tick(6);
        chk("t2_lost", lost_count, 0);
        // fill to full with one held pending, then one drop
        ready = 0;
        match_pulses(9);
        chk("t3_full", fifo_count, 8);
        chk("t3_no_loss", lost_count, 0);
        match_pulses(1);
        chk("t3_lost_one", lost_count, 1);
        ready = 1;
        tick(14);
        chk("t3_drained", fifo_count, 0);
        // interrupt threshold
        irq_en = 1; ready = 0;
        match_pulses(4);
        chk("t4_irq_set", irq, 1);
        ready = 1; tick(1); ready = 0;
        chk("t4_irq_clear", irq, 0);
        match_pulses(1);
        chk("t4_irq_reset", irq, 1);
        irq_en = 0; tick(1);
        chk("t4_irq_dis", irq, 0);
        // full with pending: push and pop together
        match_pulses(5);
        chk("t5_full", fifo_count, 8);
        ready = 1; tick(1); ready = 0;
        chk("t5_still_full", fifo_count, 8);
        ready = 1; tick(12);
        // reset mid-operation with entries and pending events
        ready = 0;
        match_pulses(5);
        ovf = 1; act = 0; val = $urandom;
        tick(1);
        rst = 0; ovf = 0;
        tick(1);
        rst = 1;
        chk("t6_count", fifo_count, 0);
        chk("t6_valid", evt_valid, 0);
        chk("t6_lost", lost_count, 0);
        chk("t6_irq", irq, 0);
        ready = 1; tick(8);
        chk("t6_no_stale", fifo_count, 0);
        // randomized traffic
        irq_en = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) act = ~act;
            mat = $urandom_range(3) == 0;
            ovf = $urandom_range(5) == 0;
            val = $urandom;
            ready = $urandom_range(2) != 0;
            if ($urandom_range(40) == 0) irq_en = ~irq_en;
            rst = $urandom_range(600) != 0;
            tick(1);
        end
        // lost counter saturation
        rst = 1; ready = 0;
        for (int i = 0; i < 700; i++) begin
            mat = ~mat;
            tick(1);
        end
        chk("lost_saturate", lost_count, 255);
        mat = 0; ovf = 0; ready = 1;
        tick(40);
        chk("final_empty", fifo_count, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
